// File: rtl/spi_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : spi_regbank
//  Purpose  : Control/status register bank behind the SPI slave port.
//             It holds NREG R/W config registers, a W1C sticky status register
//             with an address-error flag, a self-clearing command pulse
//             register, a registered read path and an interrupt output.
//  Revision : 1.0  initial release
// ============================================================================
module spi_regbank #(
   parameter int                   DW      = 8,
   parameter int                   AW      = 8,
   parameter int                   NREG    = 4,
   parameter logic [NREG*DW-1:0]   RST_VAL = '0
) (
   input  logic                 CLK,
   input  logic                 RSTX,
   input  logic                 WEN,
   input  logic [AW-1:0]        WADDR,
   input  logic [DW-1:0]        WDATA,
   input  logic                 REN,
   input  logic [AW-1:0]        RADDR,
   output logic [DW-1:0]        RDATA,
   output logic                 RVALID,
   input  logic [DW-2:0]        STAT_SET,
   output logic [NREG*DW-1:0]   REG_OUT,
   output logic [DW-1:0]        CMD_PULSE,
   output logic                 IRQ
);

   // Status sits directly above the config block, command directly above it.
   localparam logic [AW-1:0] SADDR = AW'(NREG);
   localparam logic [AW-1:0] CADDR = AW'(NREG + 1);

   logic [DW-1:0] cfg_q [NREG];
   logic [DW-1:0] status_q, status_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] cmd_q, cmd_d;
   logic          rvalid_q;
   logic          irq_q;

   logic          addr_err;
   logic [DW-1:0] w1c_mask;

   // Anything above the command address is unmapped, for reads and writes.
   assign addr_err = (WEN && (WADDR > CADDR)) || (REN && (RADDR > CADDR));
   assign w1c_mask = (WEN && (WADDR == SADDR)) ? WDATA : '0;

   // Status update: clear first, then OR in the sets so a set always wins.
   always_comb begin
      status_d = (status_q & ~w1c_mask) | {addr_err, STAT_SET};
      cmd_d    = (WEN && (WADDR == CADDR)) ? WDATA : '0;
   end

   // Read mux uses current (pre-write) register contents; holds when idle.
   always_comb begin
      rdata_d = rdata_q;
      if (REN) begin
         rdata_d = '0;
         for (int i = 0; i < NREG; i++) begin
            if (RADDR == AW'(i)) rdata_d = cfg_q[i];
         end
         if (RADDR == SADDR) rdata_d = status_q;
      end
   end

   // Configuration registers with per-register reset values.
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         for (int i = 0; i < NREG; i++) cfg_q[i] <= RST_VAL[i*DW +: DW];
      end else if (WEN) begin
         for (int i = 0; i < NREG; i++) begin
            if (WADDR == AW'(i)) cfg_q[i] <= WDATA;
         end
      end
   end

   // Status, read path, command pulse and interrupt flops.
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         status_q <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         cmd_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= status_d;
         rdata_q  <= rdata_d;
         rvalid_q <= REN;
         cmd_q    <= cmd_d;
         irq_q    <= |status_q;
      end
   end

   generate
      for (genvar g = 0; g < NREG; g++) begin : g_regout
         assign REG_OUT[g*DW +: DW] = cfg_q[g];
      end
   endgenerate

   assign RDATA     = rdata_q;
   assign RVALID    = rvalid_q;
   assign CMD_PULSE = cmd_q;
   assign IRQ       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_regbank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_spi_regbank
//  Purpose  : Self-checking bench for spi_regbank (DW=8, AW=8, NREG=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_regbank;

   localparam int          DW  = 8;
   localparam int          AW  = 8;
   localparam int          NR  = 4;
   localparam logic [31:0] RST = 32'h5A0011FF;

   logic          CLK = 1'b0;
   logic          RSTX = 1'b0;
   logic          WEN = 1'b0;
   logic [7:0]    WADDR = '0;
   logic [7:0]    WDATA = '0;
   logic          REN = 1'b0;
   logic [7:0]    RADDR = '0;
   logic [6:0]    STAT_SET = '0;
   logic [7:0]    RDATA;
   logic          RVALID;
   logic [31:0]   REG_OUT;
   logic [7:0]    CMD_PULSE;
   logic          IRQ;

   int n_checks = 0;
   int n_fail   = 0;

   spi_regbank #(.DW(DW), .AW(AW), .NREG(NR), .RST_VAL(RST)) dut (
      .CLK(CLK), .RSTX(RSTX), .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA),
      .REN(REN), .RADDR(RADDR), .RDATA(RDATA), .RVALID(RVALID),
      .STAT_SET(STAT_SET), .REG_OUT(REG_OUT), .CMD_PULSE(CMD_PULSE), .IRQ(IRQ)
   );

   always #5 CLK = ~CLK;

   // Behavioural model: what the bank should hold after each edge.
   logic [7:0] m_cfg [4];
   logic [7:0] m_status, m_rdata, m_cmd;
   logic       m_rvalid, m_irq;

   function automatic logic [31:0] m_regout();
      return {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
   endfunction

   function automatic logic [7:0] m_read(input logic [7:0] a);
      if (a < 8'd4)  return m_cfg[a[1:0]];
      if (a == 8'd4) return m_status;
      return 8'h00;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cfg[i] = RST[i*8 +: 8];
      m_status = 0; m_rdata = 0; m_cmd = 0; m_rvalid = 0; m_irq = 0;
   endtask

   task automatic idle();
      WEN = 0; REN = 0; WADDR = 0; WDATA = 0; RADDR = 0; STAT_SET = 0;
   endtask

   // Advance one clock with the current inputs and update the model.
   task automatic tick();
      logic [7:0] n_rdata, n_status, n_cmd, clr;
      logic       n_rvalid, n_irq, err;
      n_rdata  = REN ? m_read(RADDR) : m_rdata;
      n_rvalid = REN;
      err      = (WEN && WADDR > 8'd5) || (REN && RADDR > 8'd5);
      clr      = (WEN && WADDR == 8'd4) ? WDATA : 8'h00;
      n_status = (m_status & ~clr) | {err, STAT_SET};
      n_irq    = (m_status != 0);
      n_cmd    = (WEN && WADDR == 8'd5) ? WDATA : 8'h00;
      @(posedge CLK); #1;
      if (WEN && WADDR < 8'd4) m_cfg[WADDR[1:0]] = WDATA;
      m_rdata = n_rdata; m_rvalid = n_rvalid; m_status = n_status;
      m_irq = n_irq; m_cmd = n_cmd;
   endtask

   task automatic test_reset();
      n_checks++; if (REG_OUT !== 32'h5A0011FF) begin n_fail++; $display("FAIL reset_regout got %h expected %h", REG_OUT, 32'h5A0011FF); end
      n_checks++; if (RDATA !== 8'h00 || RVALID !== 1'b0) begin n_fail++; $display("FAIL reset_read got %h/%b expected 00/0", RDATA, RVALID); end
      n_checks++; if (CMD_PULSE !== 8'h00 || IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_irq got %h/%b expected 00/0", CMD_PULSE, IRQ); end
      REN = 1; RADDR = 8'd4; tick(); idle();
      n_checks++; if (RDATA !== 8'h00 || RVALID !== 1'b1) begin n_fail++; $display("FAIL reset_status got %h/%b expected 00/1", RDATA, RVALID); end
      tick();
   endtask

   task automatic test_config_rw();
      WEN = 1; WADDR = 8'd2; WDATA = 8'hC3; tick(); idle();
      n_checks++; if (REG_OUT[23:16] !== 8'hC3) begin n_fail++; $display("FAIL cfg_write got %h expected c3", REG_OUT[23:16]); end
      REN = 1; RADDR = 8'd2; tick(); idle();
      n_checks++; if (RDATA !== 8'hC3 || RVALID !== 1'b1) begin n_fail++; $display("FAIL cfg_read got %h/%b expected c3/1", RDATA, RVALID); end
      tick();
      n_checks++; if (RDATA !== 8'hC3 || RVALID !== 1'b0) begin n_fail++; $display("FAIL rdata_hold got %h/%b expected c3/0", RDATA, RVALID); end
      WEN = 1; WADDR = 8'd1; WDATA = 8'h00; tick();
      WDATA = 8'h77; REN = 1; RADDR = 8'd1; tick(); idle();
      n_checks++; if (RDATA !== 8'h00 || RVALID !== 1'b1) begin n_fail++; $display("FAIL rw_same_cycle got %h/%b expected 00/1", RDATA, RVALID); end
      REN = 1; RADDR = 8'd1; tick(); idle();
      n_checks++; if (RDATA !== 8'h77) begin n_fail++; $display("FAIL rw_after got %h expected 77", RDATA); end
   endtask

   task automatic test_status();
      STAT_SET = 7'h05; tick(); idle();
      n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b expected 0", IRQ); end
      tick();
      n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b expected 1", IRQ); end
      REN = 1; RADDR = 8'd4; tick(); idle();
      n_checks++; if (RDATA !== 8'h05) begin n_fail++; $display("FAIL status_set got %h expected 05", RDATA); end
      WEN = 1; WADDR = 8'd4; WDATA = 8'h01; tick(); idle();
      REN = 1; RADDR = 8'd4; tick(); idle();
      n_checks++; if (RDATA !== 8'h04 || IRQ !== 1'b1) begin n_fail++; $display("FAIL status_w1c got %h/%b expected 04/1", RDATA, IRQ); end
      WEN = 1; WADDR = 8'd4; WDATA = 8'h04; STAT_SET = 7'h04; tick(); idle();
      REN = 1; RADDR = 8'd4; tick(); idle();
      n_checks++; if (RDATA !== 8'h04) begin n_fail++; $display("FAIL set_wins got %h expected 04", RDATA); end
      WEN = 1; WADDR = 8'd4; WDATA = 8'h04; tick(); idle(); tick();
   endtask

   task automatic test_addr_err();
      WEN = 1; WADDR = 8'd9; WDATA = 8'hAA; tick(); idle();
      n_checks++; if (REG_OUT !== 32'h5AC377FF) begin n_fail++; $display("FAIL unmapped_write got %h expected 5ac377ff", REG_OUT); end
      tick();
      n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL err_irq got %b expected 1", IRQ); end
      REN = 1; RADDR = 8'd4; tick(); idle();
      n_checks++; if (RDATA !== 8'h80) begin n_fail++; $display("FAIL err_flag got %h expected 80", RDATA); end
      REN = 1; RADDR = 8'd9; tick(); idle();
      n_checks++; if (RDATA !== 8'h00 || RVALID !== 1'b1) begin n_fail++; $display("FAIL unmapped_read got %h/%b expected 00/1", RDATA, RVALID); end
      WEN = 1; WADDR = 8'd4; WDATA = 8'h80; tick(); idle();
      REN = 1; RADDR = 8'd4; tick(); idle();
      n_checks++; if (RDATA !== 8'h00 || IRQ !== 1'b0) begin n_fail++; $display("FAIL err_clear got %h/%b expected 00/0", RDATA, IRQ); end
      WEN = 1; WADDR = 8'd4; WDATA = 8'h80; REN = 1; RADDR = 8'd200; tick(); idle();
      REN = 1; RADDR = 8'd4; tick(); idle();
      n_checks++; if (RDATA !== 8'h80) begin n_fail++; $display("FAIL err_set_wins got %h expected 80", RDATA); end
      WEN = 1; WADDR = 8'd4; WDATA = 8'h80; tick(); idle(); tick();
   endtask

   task automatic test_back_to_back_cmd();
      WEN = 1; WADDR = 8'd5; WDATA = 8'h3C; tick();
      n_checks++; if (CMD_PULSE !== 8'h3C) begin n_fail++; $display("FAIL cmd_first got %h expected 3c", CMD_PULSE); end
      WDATA = 8'h81; tick(); idle();
      n_checks++; if (CMD_PULSE !== 8'h81) begin n_fail++; $display("FAIL cmd_second got %h expected 81", CMD_PULSE); end
      REN = 1; RADDR = 8'd5; tick(); idle();
      n_checks++; if (CMD_PULSE !== 8'h00) begin n_fail++; $display("FAIL cmd_end got %h expected 00", CMD_PULSE); end
      n_checks++; if (RDATA !== 8'h00 || RVALID !== 1'b1) begin n_fail++; $display("FAIL cmd_read got %h/%b expected 00/1", RDATA, RVALID); end
   endtask

   task automatic test_reset_mid();
      WEN = 1; WADDR = 8'd5; WDATA = 8'h5F; REN = 1; RADDR = 8'd0; tick(); idle();
      n_checks++; if (CMD_PULSE !== 8'h5F || RVALID !== 1'b1 || RDATA !== 8'hFF) begin n_fail++; $display("FAIL pre_reset got %h/%b/%h expected 5f/1/ff", CMD_PULSE, RVALID, RDATA); end
      #2 RSTX = 0;
      #1;
      n_checks++; if (CMD_PULSE !== 8'h00 || RVALID !== 1'b0) begin n_fail++; $display("FAIL async_reset got %h/%b expected 00/0", CMD_PULSE, RVALID); end
      n_checks++; if (REG_OUT !== RST) begin n_fail++; $display("FAIL async_regout got %h expected %h", REG_OUT, RST); end
      @(negedge CLK); RSTX = 1; model_reset();
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++; if (CMD_PULSE !== 8'h00 || RVALID !== 1'b0) begin n_fail++; $display("FAIL post_reset got %h/%b expected 00/0", CMD_PULSE, RVALID); end
      end
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 500; c++) begin
         WEN = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         WADDR = (r < 8) ? 8'(r) : 8'($urandom_range(8, 255));
         WDATA = 8'($urandom);
         REN = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         RADDR = (r < 8) ? 8'(r) : 8'($urandom_range(8, 255));
         STAT_SET = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'h00;
         tick();
         n_checks++; if (REG_OUT !== m_regout()) begin n_fail++; $display("FAIL rand_regout c%0d got %h expected %h", c, REG_OUT, m_regout()); end
         n_checks++; if (RDATA !== m_rdata || RVALID !== m_rvalid) begin n_fail++; $display("FAIL rand_read c%0d got %h/%b expected %h/%b", c, RDATA, RVALID, m_rdata, m_rvalid); end
         n_checks++; if (CMD_PULSE !== m_cmd) begin n_fail++; $display("FAIL rand_cmd c%0d got %h expected %h", c, CMD_PULSE, m_cmd); end
         n_checks++; if (IRQ !== m_irq) begin n_fail++; $display("FAIL rand_irq c%0d got %b expected %b", c, IRQ, m_irq); end
      end
      idle();
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK); RSTX = 1;
      tick();
      test_reset();
      test_config_rw();
      test_status();
      test_addr_err();
      test_back_to_back_cmd();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
